// File: rtl/adc_code_hist.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_code_hist: bins one channel's signed ADC codes into saturating |
// | per-bin counters with registered readback.                         |
// | Optional min/max tracking: define ADC_HIST_MINMAX_EN.              |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module adc_code_hist #(
   parameter int Nadc           = 8,
   parameter int Nch            = 18,
   parameter int Nbin_log2      = 5,
   parameter int Ncnt           = 16,
   parameter int Nsamp_log2_max = 20
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic signed [Nadc-1:0] codes [Nch],
   input  logic [$clog2(Nch)-1:0] chan_sel,
   input  logic [4:0]             n_samples_log2,
   input  logic                   start,
   input  logic                   abort,
   input  logic [Nbin_log2-1:0]   rd_addr,
   output logic [Ncnt-1:0]        rd_data,
   output logic                   busy,
   output logic                   done,
   output logic                   sat,
   output logic                   sel_err,
   output logic signed [Nadc-1:0] code_min,
   output logic signed [Nadc-1:0] code_max
);

   localparam int               CW   = $clog2(Nch);
   localparam int               NBIN = 1 << Nbin_log2;
   localparam int               SW   = Nsamp_log2_max + 1;
   localparam logic [4:0]       NMAX = 5'(Nsamp_log2_max);
   localparam logic [Nadc-1:0]  OFFS = {1'b1, {(Nadc-1){1'b0}}};
   localparam logic [Ncnt-1:0]  CMAX = '1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_ACCUM = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 start_q, start_dly_q;
   logic [CW-1:0]        sel_q, sel_d;
   logic [4:0]           nlog_q, nlog_d;
   logic [Nbin_log2-1:0] clr_addr_q, clr_addr_d;
   logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
   logic [Nbin_log2-1:0] samp_bin_q, samp_bin_d;
   logic                 samp_vld_q, samp_vld_d;
   logic [Ncnt-1:0]      bins_q [NBIN];
   logic [Ncnt-1:0]      bins_d [NBIN];
   logic [Ncnt-1:0]      rd_data_q, rd_data_d;
   logic                 sat_q, sat_d;
   logic                 sel_err_q, sel_err_d;

   logic                   start_go;
   logic                   capture;
   logic [SW-1:0]          samp_total;
   logic signed [Nadc-1:0] cur_code;
   logic [Nadc-1:0]        cur_offs;

   assign start_go   = start_q & ~start_dly_q & ~abort &
                       ((state_q == S_IDLE) | (state_q == S_DONE));
   assign samp_total = SW'(1) << nlog_q;
   assign capture    = (state_q == S_ACCUM) & (samp_cnt_q != samp_total) & ~abort;
   assign cur_code   = codes[sel_q];
   // Flipping the sign bit gives offset binary; its top bits are the bin.
   assign cur_offs   = cur_code ^ OFFS;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         start_q     <= 1'b0;
         start_dly_q <= 1'b0;
      end else begin
         start_q     <= start;
         start_dly_q <= start_q;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (start_go) state_d = S_CLEAR;
            S_CLEAR:        if (&clr_addr_q) state_d = S_ACCUM;
            S_ACCUM:        if (samp_cnt_q == samp_total) state_d = S_DONE;
            default:        state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q == S_CLEAR) | (state_q == S_ACCUM);
      done = (state_q == S_DONE);
   end

   always_comb begin
      sel_d      = sel_q;
      nlog_d     = nlog_q;
      clr_addr_d = clr_addr_q;
      samp_cnt_d = samp_cnt_q;
      samp_bin_d = samp_bin_q;
      samp_vld_d = 1'b0;
      sat_d      = sat_q;
      sel_err_d  = sel_err_q;
      bins_d     = bins_q;
      rd_data_d  = bins_q[rd_addr];

      if (start_go) begin
         sat_d      = 1'b0;
         clr_addr_d = '0;
         samp_cnt_d = '0;
         nlog_d     = (n_samples_log2 > NMAX) ? NMAX : n_samples_log2;
         if (int'(chan_sel) >= Nch) begin
            sel_d     = '0;
            sel_err_d = 1'b1;
         end else begin
            sel_d     = chan_sel;
            sel_err_d = 1'b0;
         end
      end

      if (!abort && (state_q == S_CLEAR)) begin
         bins_d[clr_addr_q] = '0;
         clr_addr_d         = clr_addr_q + Nbin_log2'(1);
      end

      if (capture) begin
         samp_bin_d = Nbin_log2'(cur_offs >> (Nadc - Nbin_log2));
         samp_vld_d = 1'b1;
         samp_cnt_d = samp_cnt_q + SW'(1);
      end

      // Increment acts on last cycle's capture, so same-bin runs never collide.
      if (!abort && (state_q == S_ACCUM) && samp_vld_q) begin
         if (bins_q[samp_bin_q] == CMAX) sat_d = 1'b1;
         else bins_d[samp_bin_q] = bins_q[samp_bin_q] + Ncnt'(1);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sel_q      <= '0;
         nlog_q     <= '0;
         clr_addr_q <= '0;
         samp_cnt_q <= '0;
         samp_bin_q <= '0;
         samp_vld_q <= 1'b0;
         sat_q      <= 1'b0;
         sel_err_q  <= 1'b0;
         rd_data_q  <= '0;
         bins_q     <= '{default: '0};
      end else begin
         sel_q      <= sel_d;
         nlog_q     <= nlog_d;
         clr_addr_q <= clr_addr_d;
         samp_cnt_q <= samp_cnt_d;
         samp_bin_q <= samp_bin_d;
         samp_vld_q <= samp_vld_d;
         sat_q      <= sat_d;
         sel_err_q  <= sel_err_d;
         rd_data_q  <= rd_data_d;
         bins_q     <= bins_d;
      end
   end

   assign rd_data = rd_data_q;
   assign sat     = sat_q;
   assign sel_err = sel_err_q;

`ifdef ADC_HIST_MINMAX_EN
   logic signed [Nadc-1:0] min_q, min_d;
   logic signed [Nadc-1:0] max_q, max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (capture) begin
         if (samp_cnt_q == '0) begin
            min_d = cur_code;
            max_d = cur_code;
         end else begin
            if (cur_code < min_q) min_d = cur_code;
            if (cur_code > max_q) max_d = cur_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         min_q <= '0;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign code_min = min_q;
   assign code_max = max_q;
`else
   assign code_min = '0;
   assign code_max = '0;
`endif

endmodule
`default_nettype wire
